// File: rtl/lcd_scanout.sv
// LCD raster scan-out: walks the 128x240 screen, reads the 4-bit framebuffer
// and streams palette-mapped RGB565 pixels over a valid/ready handshake.
module lcd_scanout #(
   parameter int SCREEN_W   = 128,
   parameter int SCREEN_H   = 240,
   parameter int SCALE_LOG2 = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   output logic [5:0]  fb_x,
   output logic [5:0]  fb_y,
   input  logic [3:0]  fb_frame,
   output logic [15:0] px_data,
   output logic        px_valid,
   input  logic        px_ready,
   output logic        busy,
   output logic        frame_done
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SEND,
      DONE
   } state_t;

   localparam logic [6:0] COL_LAST = 7'(SCREEN_W - 1);
   localparam logic [7:0] ROW_LAST = 8'(SCREEN_H - 1);

   state_t     state;
   logic [6:0] col;
   logic [7:0] row;

   assign fb_x = 6'(row >> SCALE_LOG2);
   assign fb_y = 6'(col >> SCALE_LOG2);
   assign busy = (state != IDLE);

   function automatic logic [15:0] palette(input logic [3:0] idx);
      logic [15:0] c;
      unique case (idx)
         4'd0:  c = 16'h0000;
         4'd1:  c = 16'hFFFF;
         4'd2:  c = 16'hF800;
         4'd3:  c = 16'h07E0;
         4'd4:  c = 16'h001F;
         4'd5:  c = 16'hFFE0;
         4'd6:  c = 16'h07FF;
         4'd7:  c = 16'hF81F;
         4'd8:  c = 16'h8410;
         4'd9:  c = 16'h4208;
         4'd10: c = 16'hFD20;
         4'd11: c = 16'hA145;
         4'd12: c = 16'hFE19;
         4'd13: c = 16'h0010;
         4'd14: c = 16'h0400;
         4'd15: c = 16'h8000;
         default: c = 16'h0000;
      endcase
      return c;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         row        <= '0;
         col        <= '0;
         px_data    <= '0;
         px_valid   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         // abort beats any handshake seen in the same cycle
         if (abort && state != IDLE) begin
            state    <= IDLE;
            px_valid <= 1'b0;
            row      <= '0;
            col      <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start && !abort) begin
                     state <= FETCH;
                     row   <= '0;
                     col   <= '0;
                  end
               end
               FETCH: begin
                  px_data  <= palette(fb_frame);
                  px_valid <= 1'b1;
                  state    <= SEND;
               end
               SEND: begin
                  if (px_ready) begin
                     px_valid <= 1'b0;
                     if (row == ROW_LAST && col == COL_LAST) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                     end else begin
                        state <= FETCH;
                        if (col == COL_LAST) begin
                           col <= '0;
                           row <= row + 8'd1;
                        end else begin
                           col <= col + 7'd1;
                        end
                     end
                  end
               end
               DONE: begin
                  row   <= '0;
                  col   <= '0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lcd_scanout.sv
// Directed bench for lcd_scanout: idle, full frame, backpressure,
// abort, palette sweep and asynchronous reset.
module tb_lcd_scanout;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic [5:0]  fb_x;
   logic [5:0]  fb_y;
   logic [3:0]  fb_frame;
   logic [15:0] px_data;
   logic        px_valid;
   logic        px_ready;
   logic        busy;
   logic        frame_done;

   lcd_scanout dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .fb_x       (fb_x),
      .fb_y       (fb_y),
      .fb_frame   (fb_frame),
      .px_data    (px_data),
      .px_valid   (px_valid),
      .px_ready   (px_ready),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] pal [16] = '{
      16'h0000, 16'hFFFF, 16'hF800, 16'h07E0,
      16'h001F, 16'hFFE0, 16'h07FF, 16'hF81F,
      16'h8410, 16'h4208, 16'hFD20, 16'hA145,
      16'hFE19, 16'h0010, 16'h0400, 16'h8000
   };

   bit model_mode;

   // mode 0: cell[0][0]=5, cell[10][10]=4; mode 1: index = fb_y[3:0]
   always_comb begin
      fb_frame = 4'd0;
      if (model_mode)
         fb_frame = fb_y[3:0];
      else if (fb_x == 6'd0 && fb_y == 6'd0)
         fb_frame = 4'd5;
      else if (fb_x == 6'd10 && fb_y == 6'd10)
         fb_frame = 4'd4;
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] exp_px(input int r, input int c);
      if (r < 4 && c < 4) return 16'hFFE0;
      if (r >= 40 && r < 44 && c >= 40 && c < 44) return 16'h001F;
      return 16'h0000;
   endfunction

   int          idx;
   int          done_cnt;
   int          done_idx;
   int          bad_pix;
   int          bad_hold;
   bit          hold_prev;
   logic [15:0] hold_data;
   logic [5:0]  y127, x128, y128, x_last, y_last;

   initial begin
      idx = 0; done_cnt = 0; done_idx = 0;
      bad_pix = 0; bad_hold = 0; hold_prev = 1'b0;
   end

   always @(negedge clk) begin
      if (!rst) begin
         int r, c;
         logic [15:0] e;
         if (hold_prev && (!px_valid || px_data != hold_data))
            bad_hold++;
         hold_prev = px_valid && !px_ready && !abort;
         hold_data = px_data;
         if (px_valid && px_ready && !abort) begin
            r = idx / 128;
            c = idx % 128;
            e = model_mode ? pal[(c >> 2) & 15] : exp_px(r, c);
            if (px_data != e || int'(fb_x) != (r >> 2) ||
                int'(fb_y) != (c >> 2))
               bad_pix++;
            if (idx == 127) y127 = fb_y;
            if (idx == 128) begin x128 = fb_x; y128 = fb_y; end
            if (idx == 30719) begin x_last = fb_x; y_last = fb_y; end
            idx++;
         end
         if (frame_done) begin
            done_cnt++;
            done_idx = idx;
         end
      end
   end

   task automatic start_frame(input string tag);
      idx = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk({tag, "_lat_valid0"}, 32'(px_valid), 32'd0);
      chk({tag, "_lat_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      chk({tag, "_lat_valid1"}, 32'(px_valid), 32'd1);
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      px_ready = 1'b1; model_mode = 1'b0;
      #2;
      chk("rst_valid", 32'(px_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_data", 32'(px_data), 32'd0);
      chk("rst_fbx", 32'(fb_x), 32'd0);
      chk("rst_fby", 32'(fb_y), 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      repeat (20) begin
         @(negedge clk);
         chk("idle_valid", 32'(px_valid), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_fbx", 32'(fb_x), 32'd0);
         chk("idle_fby", 32'(fb_y), 32'd0);
      end

      @(posedge clk); #1 start = 1'b1; abort = 1'b1;
      @(posedge clk); #1 start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("start_abort_busy", 32'(busy), 32'd0);

      // full frame, stray starts at pixels 5 and 20000
      start_frame("full");
      n = 0;
      while (done_cnt == 0 && n < 70000) begin
         @(posedge clk); #1;
         start = (idx == 5 || idx == 20000);
         n++;
      end
      start = 1'b0;
      chk("full_timeout", 32'(n < 70000), 32'd1);
      chk("full_busy_after", 32'(busy), 32'd0);
      chk("full_done_pulse", 32'(frame_done), 32'd0);
      chk("full_hs", idx, 30720);
      chk("full_done_cnt", done_cnt, 1);
      chk("full_done_idx", done_idx, 30720);
      chk("full_bad_pix", bad_pix, 0);
      chk("full_bad_hold", bad_hold, 0);
      chk("wrap_y127", 32'(y127), 32'd31);
      chk("wrap_x128", 32'(x128), 32'd0);
      chk("wrap_y128", 32'(y128), 32'd0);
      chk("last_x", 32'(x_last), 32'd59);
      chk("last_y", 32'(y_last), 32'd31);
      repeat (3) @(negedge clk);
      chk("full_idle_busy", 32'(busy), 32'd0);

      // backpressure, then abort at pixel 1000
      start_frame("bp");
      n = 0;
      while (idx < 1000 && n < 20000) begin
         @(posedge clk); #1;
         px_ready = ($urandom_range(0, 9) < 3);
         n++;
      end
      chk("bp_timeout", 32'(n < 20000), 32'd1);
      px_ready = 1'b0;
      n = 0;
      while (!px_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      abort = 1'b1; px_ready = 1'b1;
      @(negedge clk);
      chk("ab_valid_before", 32'(px_valid), 32'd1);
      @(posedge clk); #1 abort = 1'b0; px_ready = 1'b0;
      chk("ab_valid", 32'(px_valid), 32'd0);
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_fbx", 32'(fb_x), 32'd0);
      chk("ab_fby", 32'(fb_y), 32'd0);
      repeat (3) @(negedge clk);
      chk("ab_no_done", done_cnt, 1);
      chk("ab_hs", idx, 1000);
      chk("bp_bad_pix", bad_pix, 0);
      chk("bp_bad_hold", bad_hold, 0);

      // restart from row 0 col 0, sweeping the palette
      model_mode = 1'b1;
      px_ready = 1'b1;
      start_frame("pal");
      n = 0;
      while (idx < 80 && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("pal_timeout", 32'(n < 1000), 32'd1);
      chk("pal_bad_pix", bad_pix, 0);
      chk("pal_busy", 32'(busy), 32'd1);

      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(px_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_data", 32'(px_data), 32'd0);
      chk("mid_rst_fbx", 32'(fb_x), 32'd0);
      chk("mid_rst_fby", 32'(fb_y), 32'd0);
      chk("mid_rst_done", 32'(frame_done), 32'd0);
      #20 rst = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
